// File: rtl/sram_ctrl.sv
// Asynchronous-SRAM controller: single-beat valid/ready requests to registered
// CE#/OE#/WE# strobes with programmable wait states and bus turnaround.
module sram_ctrl #(
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned WAIT_CYC = 1,
  parameter int unsigned TURN_CYC = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic              sram_dq_oe_o,
  output logic [DATA_W-1:0] sram_dq_out_o,
  input  logic [DATA_W-1:0] sram_dq_in_i
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(WAIT_CYC);
  localparam logic [CNT_W-1:0] TURN_LAST   = (TURN_CYC > 0) ? CNT_W'(TURN_CYC - 1) : '0;
  localparam bit               HAS_TURN    = (TURN_CYC > 0);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    TURN
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                we_q;
  logic                req_ready_q;
  logic                rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                ce_n_q;
  logic                oe_n_q;
  logic                we_n_q;
  logic                dq_oe_q;
  logic [DATA_W-1:0]   dq_out_q;

  assign cnt_d = cnt_q + CNT_W'(1);

  // Outputs are set one edge ahead, for the state being entered, so every pin is a flop.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      req_ready_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      addr_q      <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i && req_ready_q) begin
            state_q     <= SETUP;
            req_ready_q <= 1'b0;
            we_q        <= req_we_i;
            addr_q      <= req_addr_i;
            ce_n_q      <= 1'b0;
            if (req_we_i) begin
              dq_oe_q  <= 1'b1;
              dq_out_q <= req_wdata_i;
            end else begin
              oe_n_q <= 1'b0;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end

        SETUP: begin
          state_q <= STROBE;
          cnt_q   <= '0;
          if (we_q) begin
            we_n_q <= 1'b0;
          end
        end

        STROBE: begin
          if (cnt_q == STROBE_LAST) begin
            state_q <= HOLD;
            if (we_q) begin
              we_n_q <= 1'b1;
            end else begin
              oe_n_q     <= 1'b1;
              rd_valid_q <= 1'b1;
              rd_data_q  <= sram_dq_in_i;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        HOLD: begin
          cnt_q   <= '0;
          ce_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
          if (HAS_TURN) begin
            state_q <= TURN;
          end else begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
          end
        end

        TURN: begin
          if (cnt_q == TURN_LAST) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        default: begin
          state_q <= IDLE;
          ce_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o   = req_ready_q;
  assign rd_valid_o    = rd_valid_q;
  assign rd_data_o     = rd_data_q;
  assign sram_addr_o   = addr_q;
  assign sram_ce_n_o   = ce_n_q;
  assign sram_oe_n_o   = oe_n_q;
  assign sram_we_n_o   = we_n_q;
  assign sram_dq_oe_o  = dq_oe_q;
  assign sram_dq_out_o = dq_out_q;

endmodule
